// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Register-and-control stage that sits around an external combinational
// shifter (h/f/il/ir -> s). It holds the working word q, always presents it to
// the shifter as sh_f, chooses the shifter operation each cycle and writes the
// shifter result back into q while a multi-step shift command is running.
//
// Commands arrive over a valid/ready handshake:
//   op 00 load  : q <= cmd_data, done next cycle
//   op 01 left  : cmd_count steps of left shift (il enters at bit 0)
//   op 10 right : cmd_count steps of right shift (ir enters at bit WIDTH-1)
//   op 11 clear : q <= 0, done next cycle
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready is a pure state decode)
//   cmd_op, cmd_count,
//   cmd_data                command fields, sampled only on acceptance
//   il, ir                  serial fill bits, passed to the shifter in RUN
//   sh_h, sh_f, sh_il,
//   sh_ir, sh_s             shifter interface (sh_f always equals q)
//   q                       current register value
//   sout / sout_valid       bit shifted out on each step, one-cycle valid
//   busy                    shift command in progress
//   done                    one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             il,
  input  logic             ir,
  output logic [1:0]       sh_h,
  output logic [WIDTH-1:0] sh_f,
  output logic             sh_il,
  output logic             sh_ir,
  input  logic [WIDTH-1:0] sh_s,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_LEFT  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;

  state_t           w_state_next;
  logic [1:0]       w_op_next;
  logic [CNT_W-1:0] w_remaining_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_sout_next;
  logic             w_sout_valid_next;
  logic             w_done_next;
  logic             w_accept;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LOAD;
      r_remaining  <= '0;
      r_q          <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_op         <= w_op_next;
      r_remaining  <= w_remaining_next;
      r_q          <= w_q_next;
      r_sout       <= w_sout_next;
      r_sout_valid <= w_sout_valid_next;
      r_done       <= w_done_next;
    end
  end

  assign w_accept = cmd_valid && (r_state == ST_IDLE);

  // Next-state and datapath decode
  always_comb begin
    w_state_next      = r_state;
    w_op_next         = r_op;
    w_remaining_next  = r_remaining;
    w_q_next          = r_q;
    w_sout_next       = r_sout;
    w_sout_valid_next = 1'b0;
    w_done_next       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD: begin
              w_q_next    = cmd_data;
              w_done_next = 1'b1;
            end
            OP_CLEAR: begin
              w_q_next    = '0;
              w_done_next = 1'b1;
            end
            default: begin
              // A zero-step shift completes immediately without touching q
              if (cmd_count == '0) begin
                w_done_next = 1'b1;
              end else begin
                w_op_next        = cmd_op;
                w_remaining_next = cmd_count;
                w_state_next     = ST_RUN;
              end
            end
          endcase
        end
      end

      ST_RUN: begin
        w_q_next          = sh_s;
        w_remaining_next  = r_remaining - CNT_W'(1);
        // The bit leaving the word is taken from q before this step's update
        w_sout_next       = (r_op == OP_LEFT) ? r_q[WIDTH-1] : r_q[0];
        w_sout_valid_next = 1'b1;
        if (r_remaining == CNT_W'(1)) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs
  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_RUN);
  assign sh_f       = r_q;
  assign sh_h       = (r_state == ST_RUN) ? r_op : 2'b00;
  assign sh_il      = (r_state == ST_RUN) ? il : 1'b0;
  assign sh_ir      = (r_state == ST_RUN) ? ir : 1'b0;
  assign q          = r_q;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             il;
  logic             ir;
  logic [1:0]       sh_h;
  logic [WIDTH-1:0] sh_f;
  logic             sh_il;
  logic             sh_ir;
  logic [WIDTH-1:0] sh_s;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_count  (cmd_count),
    .cmd_data   (cmd_data),
    .il         (il),
    .ir         (ir),
    .sh_h       (sh_h),
    .sh_f       (sh_f),
    .sh_il      (sh_il),
    .sh_ir      (sh_ir),
    .sh_s       (sh_s),
    .q          (q),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  // Stand-in for the combinational shifter unit
  always_comb begin
    case (sh_h)
      2'b01:   sh_s = {sh_f[WIDTH-2:0], sh_il};
      2'b10:   sh_s = {sh_ir, sh_f[WIDTH-1:1]};
      2'b11:   sh_s = '0;
      default: sh_s = sh_f;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then examined 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    $display("cmd op=%b count=%0d data=%b", op, cnt, data);
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
  endtask

  task automatic test_reset();
    // Power-on state
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL por_q got=%b exp=0000", q); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL por_ready got=%b exp=1", cmd_ready); end
    total++; if ({busy, done, sout_valid, sout} !== 4'b0000) begin bad++; $display("FAIL por_flags got=%b exp=0000", {busy, done, sout_valid, sout}); end
    total++; if (sh_h !== 2'b00) begin bad++; $display("FAIL por_sh_h got=%b exp=00", sh_h); end

    // Load 1011, start left shift N=3, reset after the first step
    issue(2'b00, 3'd0, 4'b1011);
    tick();
    total++; if (q !== 4'b1011) begin bad++; $display("FAIL rst_load_q got=%b exp=1011", q); end
    issue(2'b01, 3'd3, 4'b0000);
    il = 1'b1;
    tick();
    idle_cmd();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_run_busy got=%b exp=1", busy); end
    tick();
    total++; if (q !== 4'b0111) begin bad++; $display("FAIL rst_step1_q got=%b exp=0111", q); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL rst_async_q got=%b exp=0000", q); end
    total++; if ({busy, done, sout_valid} !== 3'b000) begin bad++; $display("FAIL rst_async_flags got=%b exp=000", {busy, done, sout_valid}); end
    tick();
    tick();
    rst_n = 1'b1;
    il = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_no_done cyc=%0d got=%b exp=0", i, done); end
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy); end
    end
  endtask

  task automatic test_load();
    issue(2'b00, 3'd5, 4'b1011);
    total++; if (sh_h !== 2'b00) begin bad++; $display("FAIL load_sh_h_pre got=%b exp=00", sh_h); end
    tick();
    idle_cmd();
    total++; if (q !== 4'b1011) begin bad++; $display("FAIL load_q got=%b exp=1011", q); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done got=%b exp=1", done); end
    total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL load_sout_valid got=%b exp=0", sout_valid); end
    total++; if (sh_h !== 2'b00 || sh_f !== 4'b1011) begin bad++; $display("FAIL load_sh got h=%b f=%b exp h=00 f=1011", sh_h, sh_f); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_busy got=%b exp=0", busy); end
  endtask

  task automatic test_shift_left();
    issue(2'b00, 3'd0, 4'b1011);
    tick();
    issue(2'b01, 3'd2, 4'b0000);
    il = 1'b1;
    tick();
    idle_cmd();
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL shl_run busy=%b ready=%b exp busy=1 ready=0", busy, cmd_ready); end
    total++; if (sh_h !== 2'b01 || sh_il !== 1'b1) begin bad++; $display("FAIL shl_drive h=%b il=%b exp h=01 il=1", sh_h, sh_il); end
    tick();
    total++; if (q !== 4'b0111) begin bad++; $display("FAIL shl_step1_q got=%b exp=0111", q); end
    total++; if (sout !== 1'b1 || sout_valid !== 1'b1) begin bad++; $display("FAIL shl_step1_sout got=%b/%b exp=1/1", sout, sout_valid); end
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL shl_step1_state busy=%b done=%b exp 1/0", busy, done); end
    tick();
    total++; if (q !== 4'b1111) begin bad++; $display("FAIL shl_step2_q got=%b exp=1111", q); end
    total++; if (sout !== 1'b0 || sout_valid !== 1'b1) begin bad++; $display("FAIL shl_step2_sout got=%b/%b exp=0/1", sout, sout_valid); end
    total++; if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL shl_done done=%b ready=%b busy=%b exp 1/1/0", done, cmd_ready, busy); end
    total++; if (sh_h !== 2'b00 || sh_il !== 1'b0) begin bad++; $display("FAIL shl_idle_drive h=%b il=%b exp 00/0", sh_h, sh_il); end
    tick();
    il = 1'b0;
    total++; if (done !== 1'b0 || sout_valid !== 1'b0) begin bad++; $display("FAIL shl_after done=%b sv=%b exp 0/0", done, sout_valid); end
  endtask

  task automatic test_shift_right();
    issue(2'b00, 3'd0, 4'b1001);
    tick();
    issue(2'b10, 3'd1, 4'b0000);
    ir = 1'b0;
    tick();
    idle_cmd();
    total++; if (sh_h !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL shr_run h=%b busy=%b exp 10/1", sh_h, busy); end
    tick();
    total++; if (q !== 4'b0100) begin bad++; $display("FAIL shr_q got=%b exp=0100", q); end
    total++; if (sout !== 1'b1 || sout_valid !== 1'b1) begin bad++; $display("FAIL shr_sout got=%b/%b exp=1/1", sout, sout_valid); end
    total++; if (done !== 1'b1 || sh_h !== 2'b00) begin bad++; $display("FAIL shr_done done=%b h=%b exp 1/00", done, sh_h); end
    tick();
  endtask

  task automatic test_zero_count_and_clear();
    issue(2'b00, 3'd0, 4'b1111);
    tick();
    issue(2'b10, 3'd0, 4'b0000);
    tick();
    idle_cmd();
    total++; if (q !== 4'b1111) begin bad++; $display("FAIL zc_q got=%b exp=1111", q); end
    total++; if (done !== 1'b1 || sout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zc_flags done=%b sv=%b busy=%b exp 1/0/0", done, sout_valid, busy); end
    tick();
    issue(2'b11, 3'd4, 4'b1010);
    tick();
    idle_cmd();
    total++; if (q !== 4'b0000) begin bad++; $display("FAIL clr_q got=%b exp=0000", q); end
    total++; if (done !== 1'b1 || sout_valid !== 1'b0) begin bad++; $display("FAIL clr_flags done=%b sv=%b exp 1/0", done, sout_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 3'd0, 4'b0001);
    tick();
    // Shift right N=2 with ir=1 issued while done of the load is high
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_load_done got=%b exp=1", done); end
    issue(2'b10, 3'd2, 4'b0000);
    ir = 1'b1;
    tick();
    // While busy, present a load that must not be taken until RUN ends
    issue(2'b00, 3'd0, 4'b1010);
    total++; if (busy !== 1'b1 || q !== 4'b0001) begin bad++; $display("FAIL b2b_accept busy=%b q=%b exp 1/0001", busy, q); end
    tick();
    total++; if (q !== 4'b1000 || sout !== 1'b1) begin bad++; $display("FAIL b2b_step1 q=%b sout=%b exp 1000/1", q, sout); end
    tick();
    total++; if (q !== 4'b1100 || sout !== 1'b0) begin bad++; $display("FAIL b2b_step2 q=%b sout=%b exp 1100/0", q, sout); end
    total++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_done done=%b ready=%b exp 1/1", done, cmd_ready); end
    tick();
    idle_cmd();
    ir = 1'b0;
    total++; if (q !== 4'b1010 || done !== 1'b1) begin bad++; $display("FAIL b2b_next q=%b done=%b exp 1010/1", q, done); end
    total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL b2b_next_sv got=%b exp=0", sout_valid); end
    tick();
  endtask

  task automatic test_max_count();
    int cycles;
    issue(2'b00, 3'd0, 4'b0000);
    tick();
    issue(2'b01, 3'd7, 4'b0000);
    il = 1'b1;
    tick();
    idle_cmd();
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    il = 1'b0;
    total++; if (cycles !== 7) begin bad++; $display("FAIL max_latency got=%0d exp=7", cycles); end
    total++; if (q !== 4'b1111) begin bad++; $display("FAIL max_q got=%b exp=1111", q); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    il    = 1'b0;
    ir    = 1'b0;
    idle_cmd();
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_zero_count_and_clear();
    test_back_to_back();
    test_max_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Register-and-control stage wrapped around the combinational 4-bit shifter unit (h/f/il/ir -> s).
- Holds the working word `q` and drives it into the shifter as `f`.
- Selects the shifter operation `h` each cycle and latches the shifter result `s` back into `q`.
- Accepts load, multi-step shift and clear commands over a valid/ready handshake, streams shifted-out bits, and pulses `done` on completion.

Parameters:
- WIDTH, 4, word width; must match the shifter width.
- CNT_W, 3, width of the shift-count field; max steps per command = 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 load, 01 shift left, 10 shift right, 11 clear
- cmd_count  in  CNT_W  number of shift steps (used only by ops 01/10)
- cmd_data  in  WIDTH  load value (used only by op 00)
- il  in  1  serial bit entering at bit 0 on a left shift
- ir  in  1  serial bit entering at bit WIDTH-1 on a right shift
- sh_h  out  2  shifter operation select
- sh_f  out  WIDTH  shifter data input; always equals `q`
- sh_il  out  1  shifter left-fill bit
- sh_ir  out  1  shifter right-fill bit
- sh_s  in  WIDTH  shifter result
- q  out  WIDTH  current register value
- sout  out  1  bit shifted out on the last step
- sout_valid  out  1  `sout` valid this cycle
- busy  out  1  shift command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - `q`=0, state=IDLE, remaining count=0.
  - `done`=0, `sout`=0, `sout_valid`=0.
  - `cmd_ready`=1 once reset is released.
  - Reset mid-shift aborts immediately. No `done` is issued.
- States:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - RUN: `cmd_ready`=0, `busy`=1.
  - `cmd_ready` is a pure decode of state.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
  - Command fields are sampled only at acceptance.
  - `cmd_valid` while not ready is ignored. It is neither queued nor dropped with error.
- Shifter drive:
  - sh_f=q at all times.
  - In IDLE: sh_h=00, sh_il=0, sh_ir=0.
  - In RUN: sh_h=latched op, sh_il=il, sh_ir=ir (combinational pass-through, sampled per step).
- Load (00) at acceptance: q<=cmd_data; stay IDLE; `done`=1 in the next cycle.
- Clear (11) at acceptance: q<=0; stay IDLE; `done`=1 in the next cycle.
- Shift (01/10) with cmd_count=0: q unchanged; stay IDLE; `done`=1 in the next cycle; no `sout_valid`.
- Shift with cmd_count=N>0:
  - At acceptance: latch op, remaining<=N, go to RUN.
  - Each RUN edge: q<=sh_s; remaining decrements.
  - Shifted-out bit: sout<=q[WIDTH-1] on a left shift, q[0] on a right shift; sout_valid<=1.
  - When remaining==1 at the edge: return to IDLE, done<=1.
- Latency for N steps:
  - q updates on edges k+1..k+N, where k is the acceptance edge.
  - `done` and `cmd_ready` are both high in the cycle after edge k+N.
  - A new command can be accepted in that same cycle (back-to-back).
- Output timing:
  - `done` and `sout_valid` are registered and high exactly one cycle per event.
  - `sout_valid` is 0 in the cycle after a load or clear.
- `q` wraps no counts. Bits shifted off the end are lost except through `sout`.
- N = 2^CNT_W-1 is legal, as is N > WIDTH. The word then fully fills with the serial input.

Test Plan:
- Reset with rst_n=0 mid-RUN (load 4'b1011, shift left N=3, assert reset after the 1st step) -> q=0, busy=0, done never pulses, cmd_ready=1 after release.
- Load 4'b1011 -> q=1011 next edge, done=1 for exactly one cycle, sh_h=00 throughout.
- Load 1011, shift left N=2 with il=1 -> q=0111 then 1111; sout=1 then 0; done in cycle after 2nd step; busy high 2 cycles.
- Load 1001, shift right N=1 with ir=0 -> sh_h=10 for one cycle, q=0100, sout=1, done next cycle.
- Shift with cmd_count=0, then clear after load 1111 -> first: q unchanged, done, no sout_valid; second: q=0000, done.
- Back-to-back: issue the next command in the cycle `done` is high, and hold cmd_valid during RUN -> new command accepted with no gap; commands presented while busy are not accepted.
